lock_entry_controller: RTL and testbench

LOCK_ENTRY_CONTROLLER -- requirements
Module: lock_entry_controller

---
 rtl/lock_entry_controller.sv | 167 ++++++++++++++++
 tb/tb_lock_entry_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_entry_controller.sv
// Keypad lock: a code is set by entering it twice, then the same code unlocks.
// Optional lockout after MAX_FAILS consecutive wrong codes, enabled by defining LOCKOUT_EN.
module lock_entry_controller #(
  parameter int DIGITS         = 4,
  parameter int CODE_LENGTH    = 4 * DIGITS,
  parameter int COUNTER_WIDTH  = $clog2(DIGITS),
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               key,
  output logic                     locked,
  output logic                     lockout,
  output logic                     error,
  output logic [COUNTER_WIDTH:0]   digit_count,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    READ1        = 3'd0,
    READ2        = 3'd1,
    CHECK_NEW    = 3'd2,
    READ_LOCKED  = 3'd3,
    CHECK_LOCKED = 3'd4,
    LOCKOUT      = 3'd5
  } state_t;

  localparam logic [COUNTER_WIDTH:0] LAST_DIGIT = (COUNTER_WIDTH + 1)'(DIGITS - 1);

  if (DIGITS < 2 || CODE_LENGTH != 4 * DIGITS || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("lock_entry_controller: unsupported parameter set");
  end

  state_t                 state_q;
  logic [3:0]             key_prev;
  logic [CODE_LENGTH-1:0] entry;
  logic [CODE_LENGTH-1:0] candidate;
  logic [CODE_LENGTH-1:0] code;
  logic [CODE_LENGTH-1:0] entry_next;
  logic                   press;
  logic [3:0]             digit;
  logic                   final_digit;

`ifdef LOCKOUT_EN
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TIMER_W = $clog2(LOCKOUT_CYCLES + 1);
  logic [FAIL_W-1:0]  fail_count;
  logic [TIMER_W-1:0] lock_timer;
`else
  assign lockout = 1'b0;
`endif

  // A press is only a single low bit directly after an all-released cycle.
  always_comb begin
    press = 1'b0;
    digit = 4'd0;
    if (key_prev == 4'b1111) begin
      case (key)
        4'b1110: begin press = 1'b1; digit = 4'd0; end
        4'b1101: begin press = 1'b1; digit = 4'd1; end
        4'b1011: begin press = 1'b1; digit = 4'd2; end
        4'b0111: begin press = 1'b1; digit = 4'd3; end
        default: ;
      endcase
    end
  end

  assign entry_next  = {entry[CODE_LENGTH-5:0], digit};
  assign final_digit = press && (digit_count == LAST_DIGIT);
  assign state       = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= READ1;
      locked      <= 1'b0;
      error       <= 1'b0;
      digit_count <= '0;
      entry       <= '0;
      candidate   <= '0;
      code        <= '0;
      key_prev    <= 4'b1111;
`ifdef LOCKOUT_EN
      lockout     <= 1'b0;
      fail_count  <= '0;
      lock_timer  <= '0;
`endif
    end else begin
      key_prev <= key;
      error    <= 1'b0;
      case (state_q)
        READ1: if (press) begin
          entry <= entry_next;
          if (final_digit) begin
            candidate   <= entry_next;
            digit_count <= '0;
            state_q     <= READ2;
          end else begin
            digit_count <= digit_count + 1'b1;
          end
        end
        READ2, READ_LOCKED: if (press) begin
          entry       <= entry_next;
          digit_count <= digit_count + 1'b1;
          if (final_digit) state_q <= (state_q == READ2) ? CHECK_NEW : CHECK_LOCKED;
        end
        CHECK_NEW: begin
          digit_count <= '0;
          if (entry == candidate) begin
            code    <= candidate;
            locked  <= 1'b1;
            state_q <= READ_LOCKED;
          end else begin
            error   <= 1'b1;
            state_q <= READ1;
          end
        end
        CHECK_LOCKED: begin
          digit_count <= '0;
          if (entry == code) begin
            locked  <= 1'b0;
            state_q <= READ1;
`ifdef LOCKOUT_EN
            fail_count <= '0;
`endif
          end else begin
            error <= 1'b1;
`ifdef LOCKOUT_EN
            fail_count <= fail_count + 1'b1;
            if (fail_count == FAIL_W'(MAX_FAILS - 1)) begin
              lockout    <= 1'b1;
              lock_timer <= '0;
              state_q    <= LOCKOUT;
            end else begin
              state_q <= READ_LOCKED;
            end
`else
            state_q <= READ_LOCKED;
`endif
          end
        end
`ifdef LOCKOUT_EN
        // Keys are ignored here; the lock stays engaged when the timer expires.
        LOCKOUT: begin
          if (lock_timer == TIMER_W'(LOCKOUT_CYCLES - 1)) begin
            lock_timer <= '0;
            fail_count <= '0;
            lockout    <= 1'b0;
            state_q    <= READ_LOCKED;
          end else begin
            lock_timer <= lock_timer + 1'b1;
          end
        end
`endif
        default: begin
          state_q     <= READ1;
          locked      <= 1'b0;
          digit_count <= '0;
`ifdef LOCKOUT_EN
          lockout     <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_entry_controller.sv
// Bench for lock_entry_controller: directed and randomized code entries checked
// against a transaction-level model of the set / unlock / lockout rules.
module tb_lock_entry_controller;

  localparam int DIGITS         = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 20;
`ifdef LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key   = 4'hF;
  logic       locked;
  logic       lockout;
  logic       error;
  logic [2:0] digit_count;
  logic [2:0] state;

  lock_entry_controller #(
    .DIGITS         (DIGITS),
    .CODE_LENGTH    (4 * DIGITS),
    .COUNTER_WIDTH  (2),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .locked      (locked),
    .lockout     (lockout),
    .error       (error),
    .digit_count (digit_count),
    .state       (state)
  );

  always #5 clock = ~clock;

  int n_checks   = 0;
  int n_errors   = 0;
  int err_pulses = 0;

  // Reference model: codes are nibble sequences, first-pressed digit most significant.
  bit          m_locked, m_confirm;
  logic [15:0] m_candidate, m_code;
  int          m_fails, m_err_total;
  int          e_mid_state, e_mid_dc, e_state;
  bit          e_check, e_err, e_lockout;
  logic [15:0] rseq;

  always @(negedge clock) if (reset && error) err_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] digit_key(input int d);
    logic [3:0] one;
    one = 4'b0001 << d;
    return ~one;
  endfunction

  function automatic logic [15:0] rand_seq();
    logic [15:0] s;
    for (int i = 0; i < 4; i++) s[4*i +: 4] = 4'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_confirm = 0; m_candidate = '0; m_code = '0; m_fails = 0;
  endtask

  task automatic model_apply(input logic [15:0] seq);
    e_err = 0; e_lockout = 0; e_check = 1; e_state = 0;
    if (!m_locked && !m_confirm) begin
      m_candidate = seq; m_confirm = 1;
      e_mid_state = 1; e_mid_dc = 0; e_check = 0;
    end else if (!m_locked) begin
      m_confirm = 0; e_mid_state = 2; e_mid_dc = 4;
      if (seq == m_candidate) begin m_locked = 1; m_code = seq; e_state = 3; end
      else begin e_err = 1; m_err_total++; e_state = 0; end
    end else begin
      e_mid_state = 4; e_mid_dc = 4;
      if (seq == m_code) begin m_locked = 0; m_fails = 0; e_state = 0; end
      else begin
        e_err = 1; m_err_total++; m_fails++;
        if (LOCK_EN && m_fails >= MAX_FAILS) begin e_lockout = 1; e_state = 5; m_fails = 0; end
        else e_state = 3;
      end
    end
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic press(input int d, input int hold, input int gap);
    key = digit_key(d);
    repeat (hold) @(negedge clock);
    key = 4'hF;
    repeat (gap + 1) @(negedge clock);
  endtask

  task automatic final_digit(input int d);
    key = digit_key(d);
    @(negedge clock);
    check("state_after_last", state, e_mid_state);
    check("count_after_last", digit_count, e_mid_dc);
    if (!e_check) begin
      key = 4'hF;
      @(negedge clock);
    end else begin
      @(negedge clock);
      check("error_pulse", error, e_err);
      check("locked", locked, m_locked);
      check("state_after_check", state, e_state);
      check("count_cleared", digit_count, 0);
      check("lockout_set", lockout, e_lockout);
      @(negedge clock);
      check("error_one_cycle", error, 0);
      key = 4'hF;
      if (e_lockout) begin
        for (int k = 3; k < LOCKOUT_CYCLES + 1; k++) begin
          check("lockout_hold", lockout, 1);
          check("count_in_lockout", digit_count, 0);
          key = 4'($urandom_range(0, 15));
          @(negedge clock);
        end
        check("lockout_last", lockout, 1);
        key = 4'hF;
        @(negedge clock);
        check("lockout_release", lockout, 0);
        check("state_after_lockout", state, 3);
        check("locked_after_lockout", locked, 1);
        check("count_after_lockout", digit_count, 0);
      end else begin
        @(negedge clock);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic do_entry(input logic [15:0] seq, input bit skip_first);
    model_apply(seq);
    for (int i = (skip_first ? 1 : 0); i < 3; i++) begin
      press(int'(seq[12-4*i +: 2]), $urandom_range(1, 3), $urandom_range(0, 2));
      check("digit_count", digit_count, i + 1);
    end
    final_digit(int'(seq[1:0]));
    check("err_pulses", err_pulses, m_err_total);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    m_err_total = 0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_lockout", lockout, 0);
    check("rst_error", error, 0);
    check("rst_count", digit_count, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Set, unlock, then a mismatched set.
    do_entry(16'h0123, 0);
    do_entry(16'h0123, 0);
    do_entry(16'h0123, 0);
    do_entry(16'h0123, 0);
    do_entry(16'h0122, 0);
    check("mismatch_state", state, 0);
    check("mismatch_locked", locked, 0);

    // Key rules: multi-key ignored, held key counted once, chained patterns ignored.
    do_entry(16'h0123, 0);
    do_entry(16'h0123, 0);
    key = 4'b1100; repeat (3) @(negedge clock);
    key = 4'hF;    @(negedge clock);
    key = 4'b1110; repeat (10) @(negedge clock);
    key = 4'hF;    @(negedge clock);
    check("rule_single_accept", digit_count, 1);
    key = 4'b1100; @(negedge clock);
    key = 4'b1110; @(negedge clock);
    key = 4'b0111; @(negedge clock);
    key = 4'hF;    @(negedge clock);
    check("rule_no_chain", digit_count, 1);
    do_entry(16'h0123, 1);
    check("rule_unlocked", locked, 0);

    // Repeated wrong codes while locked.
    do_entry(16'h0123, 0);
    do_entry(16'h0123, 0);
    repeat (3) do_entry(16'h3333, 0);
    do_entry(16'h0123, 0);

    for (int n = 0; n < 40; n++) begin
      rseq = rand_seq();
      if ($urandom_range(0, 1) == 1) begin
        if (m_locked) rseq = m_code;
        else if (m_confirm) rseq = m_candidate;
      end
      do_entry(rseq, 0);
    end

    // Reset in the middle of an entry while locked.
    if (!m_locked) begin
      if (!m_confirm) do_entry(16'h2301, 0);
      do_entry(m_candidate, 0);
    end
    press(1, 1, 0);
    press(2, 2, 1);
    check("pre_reset_count", digit_count, 2);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("midrst_locked", locked, 0);
    check("midrst_count", digit_count, 0);
    check("midrst_state", state, 0);
    check("midrst_code", dut.code, 0);
    check("midrst_error", error, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_entry(16'h1230, 0);
    do_entry(16'h1230, 0);
    check("final_locked", locked, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
